grid_mover: RTL and testbench

Parametrised player/agent movement engine for the tile maze.
- Moves one agent through a GRID_W x GRID_H grid of cells at sub-cell resolution, advancing one sub-step per step_tick.
- Reads the maze BRAM only on cell crossings, to check walls, and blocks moves off the grid edge.
- Reports picked-up collectibles and clears them in the BRAM through a write port.
- Sits between the button debouncer / speed selector (source of step_tick) and the maze BRAM, energy logic and renderer.

---
 rtl/maze_pkg.sv | 38 +++
 rtl/grid_mover_if.sv | 25 ++
 rtl/axis_stepper.sv | 43 ++++
 rtl/grid_mover.sv | 270 +++++++++++++++++++++++++++
 tb/tb_grid_mover.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze cell, collectible, direction and button encodings
// Purpose: constants and types used by grid_mover and axis_stepper.
// Ports:   none (package).
package maze_pkg;

  // Maze BRAM word layout
  localparam int WALL_BIT = 0;
  localparam int COLL_LSB = 1;
  localparam int COLL_MSB = 3;

  // Collectible codes stored in bits [COLL_MSB:COLL_LSB]; only 1..3 can be picked up
  localparam logic [2:0] COLL_NONE   = 3'd0;
  localparam logic [2:0] COLL_SMALL  = 3'd1;
  localparam logic [2:0] COLL_MEDIUM = 3'd2;
  localparam logic [2:0] COLL_LARGE  = 3'd3;

  // Movement direction pulse encodings
  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_POS  = 2'd1;
  localparam logic [1:0] DIR_NEG  = 2'd2;

  // Button vector indices: btn = {down, right, left, up}
  localparam int BTN_UP    = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_DOWN  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EVAL
  } mover_state_t;

  function automatic logic is_pickup(input logic [2:0] code);
    return (code >= COLL_SMALL) && (code <= COLL_LARGE);
  endfunction

endpackage

// File: rtl/grid_mover_if.sv
// rtl/grid_mover_if.sv - maze BRAM read/write port bundle
// Purpose: groups the BRAM read and write handshake between the mover and the maze memory.
// Ports:   master = mover side (drives strobes/addresses/write data, receives rd_data);
//          slave  = BRAM side.
interface grid_mover_if #(
  parameter int AW     = 8,
  parameter int CELL_W = 9
);
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [CELL_W-1:0] rd_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [CELL_W-1:0] wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/axis_stepper.sv
// rtl/axis_stepper.sv - one-axis sub-step / cell-crossing decision
// Purpose: for the current cell and sub position on one axis and a move direction,
//          decides whether the move stays inside the cell or needs a crossing, whether
//          the crossing would leave the grid, and produces the stepped and committed values.
// Ports:   pos_i/sub_i current position, neg_i move direction (1 = towards 0);
//          need_cross_o, off_grid_o decision flags; sub_step_o in-cell result;
//          pos_tgt_o/sub_wrap_o values committed after a successful crossing.
module axis_stepper #(
  parameter int N         = 16,
  parameter int SUB_STEPS = 7,
  parameter int PW        = $clog2(N),
  parameter int SW        = $clog2(SUB_STEPS)
) (
  input  logic [PW-1:0] pos_i,
  input  logic [SW-1:0] sub_i,
  input  logic          neg_i,
  output logic          need_cross_o,
  output logic          off_grid_o,
  output logic [SW-1:0] sub_step_o,
  output logic [SW-1:0] sub_wrap_o,
  output logic [PW-1:0] pos_tgt_o
);
  localparam logic [SW-1:0] SUB_MAX = SW'(SUB_STEPS - 1);
  localparam logic [SW-1:0] SUB_ONE = SW'(1);
  localparam logic [PW-1:0] POS_MAX = PW'(N - 1);
  localparam logic [PW-1:0] POS_ONE = PW'(1);

  always_comb begin
    if (neg_i) begin
      need_cross_o = (sub_i == '0);
      off_grid_o   = (pos_i == '0);
      sub_step_o   = sub_i - SUB_ONE;
      sub_wrap_o   = SUB_MAX;
      pos_tgt_o    = pos_i - POS_ONE;
    end else begin
      need_cross_o = (sub_i == SUB_MAX);
      off_grid_o   = (pos_i == POS_MAX);
      sub_step_o   = sub_i + SUB_ONE;
      sub_wrap_o   = '0;
      pos_tgt_o    = pos_i + POS_ONE;
    end
  end
endmodule

// File: rtl/grid_mover.sv
// rtl/grid_mover.sv - tile-maze agent movement engine
// Purpose: moves one agent through a GRID_W x GRID_H grid at sub-cell resolution, reading
//          the maze BRAM only on cell crossings (wall check), refusing moves off the grid,
//          and reporting/clearing collectibles through the BRAM write port.
// Ports:   sysclk/reset clock and sync active-high reset; en global freeze;
//          step_tick/btn/has_energy move request; init_load/init_x/init_y position load;
//          bram BRAM read/write bundle (master side);
//          pos_x/pos_y/sub_x/sub_y position; dir/blocked/pickup_valid/pickup_type result
//          pulses; busy = crossing in flight.
module grid_mover #(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 16,
  parameter int SUB_STEPS = 7,
  parameter int RD_LAT    = 1,
  parameter int CELL_W    = 9,
  parameter int XW        = $clog2(GRID_W),
  parameter int YW        = $clog2(GRID_H),
  parameter int SW        = $clog2(SUB_STEPS),
  parameter int AW        = $clog2(GRID_W * GRID_H)
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          en,
  input  logic          step_tick,
  input  logic [3:0]    btn,
  input  logic          has_energy,
  input  logic          init_load,
  input  logic [XW-1:0] init_x,
  input  logic [YW-1:0] init_y,
  grid_mover_if.master  bram,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic [SW-1:0] sub_x,
  output logic [SW-1:0] sub_y,
  output logic [1:0]    dir,
  output logic          blocked,
  output logic          pickup_valid,
  output logic [2:0]    pickup_type,
  output logic          busy
);
  import maze_pkg::*;

  localparam int            CW         = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LAT_LAST   = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [SW-1:0] SUB_CENTRE = SW'(SUB_STEPS / 2);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(GRID_W);
  localparam logic [CELL_W-1:0] COLL_MASK =
    CELL_W'(((1 << (COLL_MSB + 1)) - 1) ^ ((1 << COLL_LSB) - 1));

  mover_state_t      state_q, state_d;
  logic [XW-1:0]     pos_x_q, pos_x_d;
  logic [YW-1:0]     pos_y_q, pos_y_d;
  logic [SW-1:0]     sub_x_q, sub_x_d;
  logic [SW-1:0]     sub_y_q, sub_y_d;
  logic              axis_y_q, axis_y_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     lat_q, lat_d;
  logic [1:0]        dir_q, dir_d;
  logic              blocked_q, blocked_d;
  logic              pickup_valid_q, pickup_valid_d;
  logic [2:0]        pickup_type_q, pickup_type_d;
  logic              rd_en_q, rd_en_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [CELL_W-1:0] wr_data_q, wr_data_d;

  // Button priority decode: up > left > right > down
  logic mv_y, mv_neg;
  always_comb begin
    mv_y   = 1'b0;
    mv_neg = 1'b0;
    if (btn[BTN_UP]) begin
      mv_y   = 1'b1;
      mv_neg = 1'b1;
    end else if (btn[BTN_LEFT]) begin
      mv_y   = 1'b0;
      mv_neg = 1'b1;
    end else if (btn[BTN_RIGHT]) begin
      mv_y   = 1'b0;
      mv_neg = 1'b0;
    end else if (btn[BTN_DOWN]) begin
      mv_y   = 1'b1;
      mv_neg = 1'b0;
    end
  end

  // In IDLE the steppers look at the live buttons; afterwards at the latched move,
  // so button changes during a crossing cannot alter it.
  logic axis_y, axis_neg;
  assign axis_y   = (state_q == ST_IDLE) ? mv_y   : axis_y_q;
  assign axis_neg = (state_q == ST_IDLE) ? mv_neg : neg_q;

  logic          x_cross, x_off, y_cross, y_off;
  logic [SW-1:0] x_sub_step, x_sub_wrap, y_sub_step, y_sub_wrap;
  logic [XW-1:0] x_tgt;
  logic [YW-1:0] y_tgt;

  axis_stepper #(.N(GRID_W), .SUB_STEPS(SUB_STEPS), .PW(XW), .SW(SW)) u_step_x (
    .pos_i       (pos_x_q),
    .sub_i       (sub_x_q),
    .neg_i       (axis_neg),
    .need_cross_o(x_cross),
    .off_grid_o  (x_off),
    .sub_step_o  (x_sub_step),
    .sub_wrap_o  (x_sub_wrap),
    .pos_tgt_o   (x_tgt)
  );

  axis_stepper #(.N(GRID_H), .SUB_STEPS(SUB_STEPS), .PW(YW), .SW(SW)) u_step_y (
    .pos_i       (pos_y_q),
    .sub_i       (sub_y_q),
    .neg_i       (axis_neg),
    .need_cross_o(y_cross),
    .off_grid_o  (y_off),
    .sub_step_o  (y_sub_step),
    .sub_wrap_o  (y_sub_wrap),
    .pos_tgt_o   (y_tgt)
  );

  logic          need_cross, off_grid;
  logic [XW-1:0] tgt_x;
  logic [YW-1:0] tgt_y;
  logic [AW-1:0] tgt_addr;
  logic [2:0]    cell_code;

  assign need_cross = axis_y ? y_cross : x_cross;
  assign off_grid   = axis_y ? y_off   : x_off;
  assign tgt_x      = axis_y ? pos_x_q : x_tgt;
  assign tgt_y      = axis_y ? y_tgt   : pos_y_q;
  assign tgt_addr   = AW'(tgt_y) * ROW_STRIDE + AW'(tgt_x);
  assign cell_code  = bram.rd_data[COLL_MSB:COLL_LSB];

  always_comb begin
    state_d        = state_q;
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    sub_x_d        = sub_x_q;
    sub_y_d        = sub_y_q;
    axis_y_d       = axis_y_q;
    neg_d          = neg_q;
    lat_d          = lat_q;
    rd_addr_d      = rd_addr_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    pickup_type_d  = pickup_type_q;
    // Strobes are pulses: low unless asserted this cycle (also covers en = 0)
    dir_d          = DIR_NONE;
    blocked_d      = 1'b0;
    pickup_valid_d = 1'b0;
    rd_en_d        = 1'b0;
    wr_en_d        = 1'b0;

    if (en) begin
      if (init_load) begin
        // Overrides any pending tick and abandons an in-flight crossing
        pos_x_d = init_x;
        pos_y_d = init_y;
        sub_x_d = SUB_CENTRE;
        sub_y_d = SUB_CENTRE;
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (step_tick && (|btn) && has_energy) begin
              if (!need_cross) begin
                if (axis_y) sub_y_d = y_sub_step;
                else        sub_x_d = x_sub_step;
                dir_d = axis_neg ? DIR_NEG : DIR_POS;
              end else if (off_grid) begin
                blocked_d = 1'b1;
              end else begin
                rd_en_d   = 1'b1;
                rd_addr_d = tgt_addr;
                axis_y_d  = mv_y;
                neg_d     = mv_neg;
                lat_d     = '0;
                state_d   = ST_READ;
              end
            end
          end
          ST_READ: begin
            if (lat_q == LAT_LAST) state_d = ST_EVAL;
            else                   lat_d   = lat_q + CNT_ONE;
          end
          ST_EVAL: begin
            state_d = ST_IDLE;
            if (bram.rd_data[WALL_BIT]) begin
              blocked_d = 1'b1;
            end else begin
              if (axis_y) begin
                pos_y_d = y_tgt;
                sub_y_d = y_sub_wrap;
              end else begin
                pos_x_d = x_tgt;
                sub_x_d = x_sub_wrap;
              end
              dir_d = axis_neg ? DIR_NEG : DIR_POS;
              if (is_pickup(cell_code)) begin
                pickup_valid_d = 1'b1;
                pickup_type_d  = cell_code + 3'd1;
                wr_en_d        = 1'b1;
                wr_addr_d      = rd_addr_q;
                wr_data_d      = bram.rd_data & ~COLL_MASK;
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pos_x_q        <= init_x;
      pos_y_q        <= init_y;
      sub_x_q        <= SUB_CENTRE;
      sub_y_q        <= SUB_CENTRE;
      axis_y_q       <= 1'b0;
      neg_q          <= 1'b0;
      lat_q          <= '0;
      dir_q          <= DIR_NONE;
      blocked_q      <= 1'b0;
      pickup_valid_q <= 1'b0;
      pickup_type_q  <= 3'd0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      sub_x_q        <= sub_x_d;
      sub_y_q        <= sub_y_d;
      axis_y_q       <= axis_y_d;
      neg_q          <= neg_d;
      lat_q          <= lat_d;
      dir_q          <= dir_d;
      blocked_q      <= blocked_d;
      pickup_valid_q <= pickup_valid_d;
      pickup_type_q  <= pickup_type_d;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
    end
  end

  assign bram.rd_en   = rd_en_q;
  assign bram.rd_addr = rd_addr_q;
  assign bram.wr_en   = wr_en_q;
  assign bram.wr_addr = wr_addr_q;
  assign bram.wr_data = wr_data_q;

  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign sub_x        = sub_x_q;
  assign sub_y        = sub_y_q;
  assign dir          = dir_q;
  assign blocked      = blocked_q;
  assign pickup_valid = pickup_valid_q;
  assign pickup_type  = pickup_type_q;
  assign busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_grid_mover.sv
// tb/tb_grid_mover.sv - scoreboard bench for grid_mover
module tb_grid_mover;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       step_tick = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       has_energy = 1'b1;
  logic       init_load = 1'b0;
  logic [3:0] init_x = 4'd5;
  logic [3:0] init_y = 4'd5;
  logic [3:0] pos_x, pos_y;
  logic [2:0] sub_x, sub_y;
  logic [1:0] dir;
  logic       blocked, pickup_valid, busy;
  logic [2:0] pickup_type;
  logic       mark = 1'b0;

  localparam logic [3:0] UP = 4'b0001, LEFT = 4'b0010, UPRIGHT = 4'b0101;

  grid_mover_if #(.AW(8), .CELL_W(9)) bus ();

  grid_mover #(.GRID_W(16), .GRID_H(16), .SUB_STEPS(7), .RD_LAT(1), .CELL_W(9)) dut (
    .sysclk(clk), .reset(reset), .en(en), .step_tick(step_tick), .btn(btn),
    .has_energy(has_energy), .init_load(init_load), .init_x(init_x), .init_y(init_y),
    .bram(bus), .pos_x(pos_x), .pos_y(pos_y), .sub_x(sub_x), .sub_y(sub_y), .dir(dir),
    .blocked(blocked), .pickup_valid(pickup_valid), .pickup_type(pickup_type), .busy(busy)
  );

  always #5 clk = ~clk;

  // BRAM model: one-cycle registered read
  logic [8:0] mem [256];
  logic [8:0] rdq = 9'h000;
  always @(posedge clk) if (bus.rd_en) rdq <= mem[bus.rd_addr];
  assign bus.rd_data = rdq;

  int cyc = 0, tick_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (step_tick && mark) tick_cyc <= cyc;
  end

  typedef struct {
    logic rd; int addr; logic [1:0] d; logic blk; logic pv; int pt;
    logic wr; int wa; int wd; int px; int py; int sx; int sy; int lat;
  } ev_t;
  ev_t q[$];
  ev_t e;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic rd, input int addr, input logic [1:0] d, input logic blk,
                      input logic pv, input int pt, input logic wr, input int wa, input int wd,
                      input int px, input int py, input int sx, input int sy, input int lat);
    ev_t n;
    n.rd = rd; n.addr = addr; n.d = d; n.blk = blk; n.pv = pv; n.pt = pt;
    n.wr = wr; n.wa = wa; n.wd = wd; n.px = px; n.py = py; n.sx = sx; n.sy = sy; n.lat = lat;
    q.push_back(n);
  endtask

  task automatic push_step(input int px, input int py, input int sx, input int sy);
    push(0, 0, 2'd2, 0, 0, 0, 0, 0, 0, px, py, sx, sy, 1);
  endtask

  // Monitor: every cycle with any output pulse consumes one expected event
  always @(negedge clk) begin
    if (!reset && (bus.rd_en || bus.wr_en || blocked || pickup_valid || dir != 2'd0)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event rd=%0b wr=%0b blk=%0b pv=%0b dir=%0d required=none",
                 bus.rd_en, bus.wr_en, blocked, pickup_valid, dir);
      end else begin
        e = q.pop_front();
        chk("strobes", int'({bus.rd_en, blocked, pickup_valid, bus.wr_en}),
            int'({e.rd, e.blk, e.pv, e.wr}));
        chk("dir", int'(dir), int'(e.d));
        chk("pos_x", int'(pos_x), e.px);
        chk("pos_y", int'(pos_y), e.py);
        chk("sub_x", int'(sub_x), e.sx);
        chk("sub_y", int'(sub_y), e.sy);
        chk("latency", cyc - tick_cyc, e.lat);
        if (e.rd) chk("rd_addr", int'(bus.rd_addr), e.addr);
        if (e.pv) chk("pickup_type", int'(pickup_type), e.pt);
        if (e.wr) begin
          chk("wr_addr", int'(bus.wr_addr), e.wa);
          chk("wr_data", int'(bus.wr_data), e.wd);
        end
      end
    end
  end

  task automatic settle();
    repeat (5) @(negedge clk);
  endtask

  task automatic tick(input logic [3:0] b);
    @(negedge clk);
    btn = b; step_tick = 1'b1; mark = 1'b1;
    @(negedge clk);
    step_tick = 1'b0; mark = 1'b0;
  endtask

  task automatic load(input int x, input int y);
    @(negedge clk);
    init_load = 1'b1; init_x = 4'(x); init_y = 4'(y);
    @(negedge clk);
    init_load = 1'b0;
  endtask

  // From (5,5) sub_y 3: three in-cell up steps down to sub_y 0
  task automatic walk_up();
    for (int i = 0; i < 3; i++) begin
      push_step(5, 5, 3, 2 - i);
      tick(UP);
      settle();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 9'h000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_pos_x", int'(pos_x), 5);
    chk("reset_pos_y", int'(pos_y), 5);
    chk("reset_sub_x", int'(sub_x), 3);
    chk("reset_sub_y", int'(sub_y), 3);
    chk("reset_dir", int'(dir), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_strobes", int'({bus.rd_en, bus.wr_en, blocked, pickup_valid}), 0);

    // Open crossing up into (5,4): address 4*16+5 = 69
    walk_up();
    push(1, 69, 2'd0, 0, 0, 0, 0, 0, 0, 5, 5, 3, 0, 1);
    push(0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 5, 4, 3, 6, 3);
    tick(UP);
    settle();

    // Wall at the target cell
    load(5, 5);
    walk_up();
    mem[69] = 9'h001;
    push(1, 69, 2'd0, 0, 0, 0, 0, 0, 0, 5, 5, 3, 0, 1);
    push(0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 5, 5, 3, 0, 3);
    tick(UP);
    settle();

    // Collectible code 3 -> type 4, bits [3:1] cleared on write-back
    load(5, 5);
    walk_up();
    mem[69] = 9'h106;
    push(1, 69, 2'd0, 0, 0, 0, 0, 0, 0, 5, 5, 3, 0, 1);
    push(0, 0, 2'd2, 0, 1, 4, 1, 69, 9'h100, 5, 4, 3, 6, 3);
    tick(UP);
    settle();

    // Code 5 is not a collectible
    load(5, 5);
    walk_up();
    mem[69] = 9'h00A;
    push(1, 69, 2'd0, 0, 0, 0, 0, 0, 0, 5, 5, 3, 0, 1);
    push(0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 5, 4, 3, 6, 3);
    tick(UP);
    settle();

    // Left edge of the grid
    load(0, 5);
    for (int i = 0; i < 3; i++) begin
      push_step(0, 5, 2 - i, 3);
      tick(LEFT);
      settle();
    end
    push(0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 5, 0, 3, 1);
    tick(LEFT);
    settle();

    // up+right: up has priority
    load(5, 5);
    push_step(5, 5, 3, 2);
    tick(UPRIGHT);
    settle();

    // Suppressed ticks: no energy, frozen, no button
    has_energy = 1'b0;
    tick(UP);
    settle();
    has_energy = 1'b1;
    en = 1'b0;
    tick(UP);
    settle();
    en = 1'b1;
    tick(4'b0000);
    settle();
    chk("suppressed_sub_y", int'(sub_y), 2);
    chk("suppressed_queue", q.size(), 0);

    // Tick while READ is ignored
    push_step(5, 5, 3, 1);
    tick(UP);
    settle();
    push_step(5, 5, 3, 0);
    tick(UP);
    settle();
    mem[69] = 9'h000;
    push(1, 69, 2'd0, 0, 0, 0, 0, 0, 0, 5, 5, 3, 0, 1);
    push(0, 0, 2'd2, 0, 0, 0, 0, 0, 0, 5, 4, 3, 6, 3);
    tick(UP);
    step_tick = 1'b1;
    @(negedge clk);
    step_tick = 1'b0;
    settle();
    chk("busy_tick_queue", q.size(), 0);
    chk("busy_tick_pos_y", int'(pos_y), 4);
    chk("busy_tick_sub_y", int'(sub_y), 6);

    // init_load during READ aborts the pickup
    load(5, 5);
    walk_up();
    mem[69] = 9'h106;
    push(1, 69, 2'd0, 0, 0, 0, 0, 0, 0, 5, 5, 3, 0, 1);
    tick(UP);
    init_load = 1'b1; init_x = 4'd2; init_y = 4'd9;
    @(negedge clk);
    init_load = 1'b0;
    settle();
    chk("abort_pos_x", int'(pos_x), 2);
    chk("abort_pos_y", int'(pos_y), 9);
    chk("abort_sub_x", int'(sub_x), 3);
    chk("abort_sub_y", int'(sub_y), 3);
    chk("abort_busy", int'(busy), 0);
    chk("final_queue", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
